// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back select codes, default special register
// indices and the MEM/WB control bundle.
package pipe_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;

    localparam int RS_REG_DEFAULT = 30;
    localparam int RA_REG_DEFAULT = 31;

    // Control half of MEM/WB; the XLEN-wide data fields travel beside it.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wren;
        logic [1:0] sel;
        logic       exc;
    } mw_ctrl_t;

endpackage

// File: rtl/mw_latch.sv
// MEM/WB pipeline register: flush inserts a bubble (priority over stall),
// stall holds, otherwise load. Asynchronous active-low clear.
module mw_latch
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  mw_ctrl_t        in_ctrl,
    input  logic [XLEN-1:0] in_o,
    input  logic [XLEN-1:0] in_d,
    input  logic [XLEN-1:0] in_pc1,
    input  logic [XLEN-1:0] in_exc_code,
    output mw_ctrl_t        ctrl,
    output logic [XLEN-1:0] o,
    output logic [XLEN-1:0] d,
    output logic [XLEN-1:0] pc1,
    output logic [XLEN-1:0] exc_code
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl     <= '0;
            o        <= '0;
            d        <= '0;
            pc1      <= '0;
            exc_code <= '0;
        end else if (flush) begin
            ctrl.valid <= 1'b0;
        end else if (!stall) begin
            ctrl     <= in_ctrl;
            o        <= in_o;
            d        <= in_d;
            pc1      <= in_pc1;
            exc_code <= in_exc_code;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB register, result select, $0 suppression and forwarding tap.
// Optional retire counter / last_pc1 when WB_RETIRE_COUNT_EN is defined.
module writeback_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RS_REG = RS_REG_DEFAULT,
    parameter int RA_REG = RA_REG_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mw_valid,
    input  logic [XLEN-1:0] mw_o,
    input  logic [XLEN-1:0] mw_d,
    input  logic [XLEN-1:0] mw_pc1,
    input  logic [4:0]      mw_rd,
    input  logic            mw_wren,
    input  logic [1:0]      mw_sel,
    input  logic            mw_exc,
    input  logic [XLEN-1:0] mw_exc_code,
    input  logic            stall,
    input  logic            flush,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]     retire_count,
    output logic [XLEN-1:0] last_pc1,
`endif
    output logic            ctrl_writeEnable,
    output logic [4:0]      ctrl_writeReg,
    output logic [XLEN-1:0] data_writeReg,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    localparam logic [4:0] RS_IDX = 5'(RS_REG);

    // jal's link index is chosen by decode; it must not alias $0 or $rstatus.
    generate
        if (RA_REG == RS_REG || RA_REG == 0) begin : g_bad_ra
            $error("writeback_stage: RA_REG must differ from RS_REG and 0");
        end
    endgenerate

    mw_ctrl_t        in_ctrl;
    mw_ctrl_t        ctrl;
    logic [XLEN-1:0] o, d, pc1, exc_code;

    always_comb begin
        in_ctrl       = '0;
        in_ctrl.valid = mw_valid;
        in_ctrl.rd    = mw_rd;
        in_ctrl.wren  = mw_wren;
        in_ctrl.sel   = mw_sel;
        in_ctrl.exc   = mw_exc;
    end

    mw_latch #(.XLEN(XLEN)) u_mw_latch (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .in_ctrl     (in_ctrl),
        .in_o        (mw_o),
        .in_d        (mw_d),
        .in_pc1      (mw_pc1),
        .in_exc_code (mw_exc_code),
        .ctrl        (ctrl),
        .o           (o),
        .d           (d),
        .pc1         (pc1),
        .exc_code    (exc_code)
    );

    logic [4:0]      wb_idx;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;

    // An exception redirects to $rstatus and writes even if the instruction had wren=0.
    always_comb begin
        wb_idx  = ctrl.rd;
        wb_data = o;
        if (ctrl.exc) begin
            wb_idx  = RS_IDX;
            wb_data = exc_code;
        end else if (ctrl.sel == WB_SEL_PC) begin
            wb_data = pc1;
        end else if (ctrl.sel == WB_SEL_MEM) begin
            wb_data = d;
        end
        wb_en = ctrl.valid && (ctrl.wren || ctrl.exc) && (wb_idx != 5'd0);
    end

    assign ctrl_writeEnable = wb_en;
    assign ctrl_writeReg    = wb_en ? wb_idx  : 5'd0;
    assign data_writeReg    = wb_en ? wb_data : '0;

    assign fwd_valid = ctrl_writeEnable;
    assign fwd_rd    = ctrl_writeReg;
    assign fwd_data  = data_writeReg;

`ifdef WB_RETIRE_COUNT_EN
    // Every held-in-stage instruction retires once, on the edge it leaves the stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_count <= '0;
            last_pc1     <= '0;
        end else if (ctrl.valid && !stall) begin
            retire_count <= retire_count + 32'd1;
            last_pc1     <= pc1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with a behavioural register-file scoreboard.
// Retire-counter checks are compiled only with WB_RETIRE_COUNT_EN.
`timescale 1ns/1ps
module tb_writeback_stage;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            mw_valid = 1'b0;
    logic [XLEN-1:0] mw_o = '0;
    logic [XLEN-1:0] mw_d = '0;
    logic [XLEN-1:0] mw_pc1 = '0;
    logic [4:0]      mw_rd = '0;
    logic            mw_wren = 1'b0;
    logic [1:0]      mw_sel = '0;
    logic            mw_exc = 1'b0;
    logic [XLEN-1:0] mw_exc_code = '0;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic            ctrl_writeEnable;
    logic [4:0]      ctrl_writeReg;
    logic [XLEN-1:0] data_writeReg;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0]     retire_count;
    logic [XLEN-1:0] last_pc1;
`endif

    int checks = 0;
    int failures = 0;
    logic [XLEN-1:0] rf [32];

    writeback_stage #(.XLEN(XLEN)) dut (
        .clock            (clock),
        .reset            (reset),
        .mw_valid         (mw_valid),
        .mw_o             (mw_o),
        .mw_d             (mw_d),
        .mw_pc1           (mw_pc1),
        .mw_rd            (mw_rd),
        .mw_wren          (mw_wren),
        .mw_sel           (mw_sel),
        .mw_exc           (mw_exc),
        .mw_exc_code      (mw_exc_code),
        .stall            (stall),
        .flush            (flush),
`ifdef WB_RETIRE_COUNT_EN
        .retire_count     (retire_count),
        .last_pc1         (last_pc1),
`endif
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .fwd_valid        (fwd_valid),
        .fwd_rd           (fwd_rd),
        .fwd_data         (fwd_data)
    );

    always #5 clock = ~clock;

    // Register file: commits the write port on the rising edge, $0 hard-wired.
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clock) begin
        if (reset && ctrl_writeEnable && ctrl_writeReg != 5'd0)
            rf[ctrl_writeReg] <= data_writeReg;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic check_port(input string tag, input logic en, input logic [4:0] idx,
                              input logic [31:0] data);
        check({tag, ".we"},   32'(ctrl_writeEnable), 32'(en));
        check({tag, ".rd"},   32'(ctrl_writeReg), 32'(idx));
        check({tag, ".data"}, data_writeReg, data);
        check({tag, ".fwd"},  {fwd_valid, 26'd0, fwd_rd} ^ fwd_data,
              {ctrl_writeEnable, 26'd0, ctrl_writeReg} ^ data_writeReg);
    endtask

    task automatic idle_inputs();
        mw_valid = 1'b0; mw_wren = 1'b0; mw_sel = 2'd0; mw_exc = 1'b0;
        mw_rd = 5'd0; mw_o = '0; mw_d = '0; mw_pc1 = '0; mw_exc_code = '0;
    endtask

    // Presents one instruction for a single capture edge, then returns to idle.
    task automatic issue(input logic wren, input logic [1:0] sel, input logic [4:0] rd,
                         input logic [31:0] o, input logic [31:0] d, input logic [31:0] pc1,
                         input logic exc, input logic [31:0] code);
        mw_valid = 1'b1; mw_wren = wren; mw_sel = sel; mw_rd = rd;
        mw_o = o; mw_d = d; mw_pc1 = pc1; mw_exc = exc; mw_exc_code = code;
        @(posedge clock); #1;
        idle_inputs();
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    initial begin
        // Reset state
        #1;
        check_port("reset_async", 1'b0, 5'd0, 32'd0);
        repeat (2) tick();
        @(negedge clock); reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_we", 32'(ctrl_writeEnable), 32'd0);
        end
        check_port("idle_port", 1'b0, 5'd0, 32'd0);

        // ALU writes
        issue(1'b1, 2'd0, 5'd2, 32'd2, 32'd0, 32'h1, 1'b0, 32'd0);
        check_port("alu_r2", 1'b1, 5'd2, 32'd2);
        issue(1'b1, 2'd0, 5'd1, 32'd3, 32'd0, 32'h2, 1'b0, 32'd0);
        check_port("alu_r1", 1'b1, 5'd1, 32'd3);
        issue(1'b1, 2'd0, 5'd3, 32'd5, 32'd0, 32'h3, 1'b0, 32'd0);
        check_port("alu_r3", 1'b1, 5'd3, 32'd5);

        // Load, jal, reserved select, $0 target
        issue(1'b1, 2'd1, 5'd4, 32'h44, 32'hDEADBEEF, 32'h4, 1'b0, 32'd0);
        check_port("load_r4", 1'b1, 5'd4, 32'hDEADBEEF);
        issue(1'b1, 2'd2, 5'd31, 32'h77, 32'h88, 32'h10, 1'b0, 32'd0);
        check_port("jal_r31", 1'b1, 5'd31, 32'h10);
        issue(1'b1, 2'd3, 5'd9, 32'h55, 32'hAA, 32'h11, 1'b0, 32'd0);
        check_port("sel3_r9", 1'b1, 5'd9, 32'h55);
        issue(1'b1, 2'd0, 5'd0, 32'd7, 32'd0, 32'h12, 1'b0, 32'd0);
        check_port("r0_suppr", 1'b0, 5'd0, 32'd0);
        issue(1'b0, 2'd0, 5'd10, 32'd12, 32'd0, 32'h13, 1'b0, 32'd0);
        check_port("no_wren", 1'b0, 5'd0, 32'd0);

        // Exception overrides rd and wren
        issue(1'b0, 2'd1, 5'd5, 32'h66, 32'h99, 32'h14, 1'b1, 32'd1);
        check_port("exc_r30", 1'b1, 5'd30, 32'd1);
        tick();
        check("rf_r2", rf[2], 32'd2);
        check("rf_r1", rf[1], 32'd3);
        check("rf_r3", rf[3], 32'd5);
        check("rf_r4", rf[4], 32'hDEADBEEF);
        check("rf_r31", rf[31], 32'h10);
        check("rf_r9", rf[9], 32'h55);
        check("rf_r0", rf[0], 32'd0);
        check("rf_r10", rf[10], 32'd0);
        check("rf_r30", rf[30], 32'd1);
        check("rf_r5", rf[5], 32'd0);

        // Stall holds the write while different inputs are offered
        issue(1'b1, 2'd0, 5'd6, 32'd9, 32'd0, 32'h20, 1'b0, 32'd0);
        stall = 1'b1;
        mw_valid = 1'b1; mw_wren = 1'b1; mw_rd = 5'd7; mw_o = 32'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_port("stall_hold", 1'b1, 5'd6, 32'd9);
        end
        flush = 1'b1;
        tick();
        check_port("flush_stall", 1'b0, 5'd0, 32'd0);
        flush = 1'b0; stall = 1'b0;
        idle_inputs();
        tick();
        check("rf_r6", rf[6], 32'd9);
        check("rf_r7", rf[7], 32'd0);

        // Flush alone drops the incoming instruction
        flush = 1'b1;
        issue(1'b1, 2'd0, 5'd11, 32'd13, 32'd0, 32'h21, 1'b0, 32'd0);
        flush = 1'b0;
        check_port("flush_only", 1'b0, 5'd0, 32'd0);

        // Asynchronous reset during a pending write
        issue(1'b1, 2'd0, 5'd8, 32'd11, 32'd0, 32'h22, 1'b0, 32'd0);
        check_port("pre_rst", 1'b1, 5'd8, 32'd11);
        #1 reset = 1'b0;
        #1 check_port("mid_rst", 1'b0, 5'd0, 32'd0);
        tick();
        @(negedge clock); reset = 1'b1;
        tick();
        check("rf_r8", rf[8], 32'd0);

`ifdef WB_RETIRE_COUNT_EN
        check("rc_reset", retire_count, 32'd0);
        issue(1'b1, 2'd0, 5'd12, 32'd1, 32'd0, 32'h100, 1'b0, 32'd0);
        tick();
        issue(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'h104, 1'b0, 32'd0);
        issue(1'b1, 2'd1, 5'd13, 32'd0, 32'd5, 32'h108, 1'b0, 32'd0);
        tick();
        issue(1'b1, 2'd0, 5'd14, 32'd2, 32'd0, 32'h10C, 1'b0, 32'd0);
        tick();
        check("rc_four", retire_count, 32'd4);
        check("rc_lastpc", last_pc1, 32'h10C);
        #2 reset = 1'b0;
        #1 check("rc_async", retire_count, 32'd0);
        check("lp_async", last_pc1, 32'd0);
        @(negedge clock); reset = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the five-stage pipeline. It holds the MEM/WB pipeline register and selects the write-back value from the ALU result, load data, link PC or exception status. It drives the register file write port and exports a forwarding tap for the execute-stage bypass. It is the last stage to change architectural state before the end-of-run register checks.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RS_REG`, 30, index of the exception-status register (`$rstatus`)
- `RA_REG`, 31, index of the link register for `jal`

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `mw_valid` in 1: MEM stage presents a real instruction
- `mw_o` in XLEN: ALU result / effective address
- `mw_d` in XLEN: data-memory read data
- `mw_pc1` in XLEN: PC+1 of the instruction
- `mw_rd` in 5: destination register
- `mw_wren` in 1: instruction writes a register
- `mw_sel` in 2: 0 ALU, 1 memory, 2 link PC, 3 reserved (treated as ALU)
- `mw_exc` in 1: overflow exception flagged upstream
- `mw_exc_code` in XLEN: value to place in `$rstatus`
- `stall` in 1: hold MEM/WB register
- `flush` in 1: replace incoming instruction with a bubble
- `ctrl_writeEnable` out 1: regfile write enable
- `ctrl_writeReg` out 5: regfile write index
- `data_writeReg` out XLEN: regfile write data
- `fwd_valid` out 1: tap holds a pending write
- `fwd_rd` out 5: tap destination register
- `fwd_data` out XLEN: tap data, equal to `data_writeReg`

## Operation
- MEM/WB register fields: `valid`, `o`, `d`, `pc1`, `rd`, `wren`, `sel`, `exc`, `exc_code`.
- Capture on each rising edge:
  - `flush`=1: clear `valid`. Flush takes priority over stall.
  - `flush`=0, `stall`=1: hold the register contents.
  - Otherwise: load the `mw_*` inputs.
- Effective write, computed combinationally from the registered fields:
  - `exc`=1: write `exc_code` to `RS_REG`. This overrides `rd` and `sel` and is forced even when `wren`=0.
  - `exc`=0, `sel`=2: write `pc1` to `rd`. Decode supplies `RA_REG` as `rd` for `jal`.
  - `exc`=0, `sel`=1: write `d` to `rd`.
  - `exc`=0, `sel`=0 or 3: write `o` to `rd`.
- `ctrl_writeEnable` = `valid` & (`wren` | `exc`) & (index ≠ 0). Writes to `$0` are always suppressed.
- When `ctrl_writeEnable`=0, `ctrl_writeReg` and `data_writeReg` are driven to 0, not left as don't-care.
- `fwd_valid`, `fwd_rd` and `fwd_data` equal `ctrl_writeEnable`, `ctrl_writeReg` and `data_writeReg` respectively.

## Timing
- Reset (`reset`=0, asynchronous): clears every register field.
  - Outputs read 0 immediately: `ctrl_writeEnable`=0, `ctrl_writeReg`=0, `data_writeReg`=0, `fwd_*`=0.
  - Retire counter (when configured) reads 0.
- Reset deassertion is sampled synchronously. The first capture happens on the first rising edge with `reset`=1.
- Latency:
  - Instruction presented at edge N is captured at N.
  - Write port is valid during cycle N→N+1.
  - Regfile commits at edge N+1, one cycle of stage latency.
- Stall with a valid instruction: the same write is re-asserted every stalled cycle. Regfile writes are idempotent, so this is legal.
- Reset asserted mid-stall or mid-write: the pending write is dropped and no partial commit occurs.
- Simultaneous `flush` and `stall`: a bubble is inserted.

## Configuration
- `WB_RETIRE_COUNT_EN` defined:
  - Adds outputs `retire_count` (out, 32) and `last_pc1` (out, XLEN).
  - The counter increments on each rising edge where `valid`=1 and `stall`=0 (stores and nops count; bubbles do not).
  - The counter wraps 0xFFFFFFFF→0.
  - `last_pc1` latches `pc1` on each counted retirement.
  - Both reset to 0.
- `WB_RETIRE_COUNT_EN` undefined: neither port exists and there is no counter logic.

## Structure
- Shared package `pipe_pkg`: `WB_SEL_ALU`=0, `WB_SEL_MEM`=1, `WB_SEL_PC`=2, the `RS_REG`/`RA_REG` defaults, and the MEM/WB bundle struct/typedef.
- One sub-module, `mw_latch`: the stall/flush-controlled pipeline register with asynchronous active-low clear. The select/suppress logic stays in `writeback_stage`.

## Test plan
1. Reset low, then high; idle inputs → all outputs 0 and no write in the first 3 cycles.
2. `mw_valid`=1, `wren`=1, `sel`=0, `rd`=2, `o`=2 at edge N → `ctrl_writeEnable`=1, `ctrl_writeReg`=2, `data_writeReg`=2 during N→N+1. Follow with `rd`=1, `o`=3 and then `rd`=3, `o`=5 → regfile reads $2=2, $1=3, $3=5.
3. Load `sel`=1, `d`=0xDEADBEEF, `rd`=4, plus `jal` `sel`=2, `pc1`=0x10, `rd`=31 → $4=0xDEADBEEF and $31=0x10. Also `rd`=0, `o`=7 → no write, $0 stays 0.
4. `exc`=1, `exc_code`=1, `rd`=5, `wren`=0 → write of 1 to $30; $5 unchanged.
5. `stall` held for 3 cycles with valid `rd`=6, `o`=9 → write held, regfile $6=9. `flush`=1 together with `stall`=1 → `ctrl_writeEnable`=0 on the next cycle.
6. With `WB_RETIRE_COUNT_EN`: 4 valid instructions plus 2 bubbles → `retire_count`=4 and `last_pc1` equals the fourth instruction's `pc1`. Counter preloaded via force to 0xFFFFFFFF plus one retire → 0. Async `reset` pulse mid-run → 0 immediately.
